// File: rtl/pu_pkg.sv
// Shared types and helpers for the pu_stream_array MAC lane array:
// FSM state encoding, a width-generic saturating adder and lane slice offsets.
package pu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Broadcast weights all read slice 0; per-lane weights follow the data slicing.
  function automatic int weight_lo(input int lane, input int width, input bit bcast);
    return bcast ? 0 : lane * width;
  endfunction

  // Adds two sign-extended operands and checks the result against a w-bit signed
  // range; with sat set the result clamps, otherwise the caller keeps the low w bits.
  function automatic logic signed [WIDE:0] sat_add(input wide_t a, input wide_t b,
                                                   input int w, input bit sat,
                                                   output logic ovf);
    logic signed [WIDE:0] sum;
    logic signed [WIDE:0] one;
    logic signed [WIDE:0] max_v;
    logic signed [WIDE:0] min_v;
    one   = 1;
    sum   = {a[WIDE-1], a} + {b[WIDE-1], b};
    max_v = (one <<< (w - 1)) - one;
    min_v = -max_v - one;
    ovf   = (sum > max_v) || (sum < min_v);
    if (ovf && sat) begin
      return sum[WIDE] ? min_v : max_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pu_lane.sv
// One MAC lane: registered signed product, accumulator with saturate/wrap
// arithmetic and a sticky overflow flag for the current job.
module pu_lane
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int SAT_EN       = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           load_i,
  input  logic                           acc_en_i,
  input  logic                           clr_i,
  input  logic signed [DATA_WIDTH-1:0]   din_i,
  input  logic signed [WEIGHT_WIDTH-1:0] win_i,
  output logic [OUTPUT_WIDTH-1:0]        acc_o,
  output logic                           ovf_o
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  logic signed [PW-1:0]           prod_q, prod_d;
  logic [OUTPUT_WIDTH-1:0]        acc_q, acc_d;
  logic                           ovf_q, ovf_d;
  logic signed [WIDE:0]           sum_full;
  logic [WIDE-OUTPUT_WIDTH:0]     sum_unused;
  logic [OUTPUT_WIDTH-1:0]        sum_lo;
  logic                           sum_ovf;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (load_i) begin
      prod_d = PW'(din_i) * PW'(win_i);
    end
    sum_full = sat_add(wide_t'(signed'(acc_q)), wide_t'(prod_q), OUTPUT_WIDTH,
                       SAT_EN != 0, sum_ovf);
    {sum_unused, sum_lo} = sum_full;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (acc_en_i) begin
      acc_d = sum_lo;
      ovf_d = ovf_q | sum_ovf;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pu_stream_array.sv
// MAC_NUM-lane streaming dot-product engine: job FSM, beat counter and a
// valid/ready result register in front of the lane array.
module pu_stream_array
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int MAC_NUM      = 8,
  parameter int K_WIDTH      = 16,
  parameter int SAT_EN       = 1,
  parameter int WEIGHT_BCAST = 1,
  localparam int WN = (WEIGHT_BCAST != 0) ? WEIGHT_WIDTH : WEIGHT_WIDTH * MAC_NUM
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [K_WIDTH-1:0]              k_len_i,
  input  logic                            clear_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [DATA_WIDTH*MAC_NUM-1:0]   din_i,
  input  logic [WN-1:0]                   win_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [OUTPUT_WIDTH*MAC_NUM-1:0] matmul_o,
  output logic [MAC_NUM-1:0]              ovf_o,
  output logic                            busy_o
);

  state_e                          state_q, state_d;
  logic [K_WIDTH-1:0]              k_len_q, k_len_d;
  logic [K_WIDTH-1:0]              cnt_q, cnt_d;
  logic                            pv_q, pv_d;
  logic                            out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH*MAC_NUM-1:0] matmul_q, matmul_d;
  logic [MAC_NUM-1:0]              ovf_q, ovf_d;
  logic                            in_ready_q, in_ready_d;
  logic                            busy_q, busy_d;

  logic                            accept;
  logic                            lane_clr;
  logic                            load_out;
  logic [OUTPUT_WIDTH*MAC_NUM-1:0] acc_all;
  logic [MAC_NUM-1:0]              lane_ovf;

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    pu_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .OUTPUT_WIDTH(OUTPUT_WIDTH),
      .SAT_EN      (SAT_EN)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (pv_d),
      .acc_en_i(pv_q),
      .clr_i   (lane_clr),
      .din_i   (din_i[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .win_i   (win_i[weight_lo(i, WEIGHT_WIDTH, WEIGHT_BCAST != 0) +: WEIGHT_WIDTH]),
      .acc_o   (acc_all[lane_lo(i, OUTPUT_WIDTH) +: OUTPUT_WIDTH]),
      .ovf_o   (lane_ovf[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    cnt_d       = cnt_q;
    pv_d        = 1'b0;
    lane_clr    = 1'b0;
    load_out    = 1'b0;
    out_valid_d = out_valid_q;
    matmul_d    = matmul_q;
    ovf_d       = ovf_q;
    accept      = in_valid_i & in_ready_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && (k_len_i != '0)) begin
          k_len_d  = k_len_i;
          cnt_d    = '0;
          lane_clr = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          pv_d  = 1'b1;
          cnt_d = cnt_q + K_WIDTH'(1);
          if (cnt_d == k_len_q) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (!out_valid_q || out_ready_i) begin
          load_out = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort leaves the result register alone; only the job pipeline is flushed.
    if (clear_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      pv_d     = 1'b0;
      lane_clr = 1'b1;
      load_out = 1'b0;
    end

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (load_out) begin
      out_valid_d = 1'b1;
      matmul_d    = acc_all;
      ovf_d       = lane_ovf;
    end

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      cnt_q       <= '0;
      pv_q        <= 1'b0;
      out_valid_q <= 1'b0;
      matmul_q    <= '0;
      ovf_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      cnt_q       <= cnt_d;
      pv_q        <= pv_d;
      out_valid_q <= out_valid_d;
      matmul_q    <= matmul_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign matmul_o    = matmul_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/pu_stream_array.md
Name: pu_stream_array

Overview:
- Parametrised successor to the first-generation processing unit: MAC_NUM signed multiply-accumulate lanes compute one K-length dot product per lane per job.
- Adds features the first generation lacks: job length programmed at run time, valid/ready handshakes on input and output, a registered multiply stage, and selectable saturating or wrapping accumulation with a per-lane sticky overflow flag.
- Optional per-lane weights.
- Sits between the streamline controller (start/len/clear) and the activation buffer (result sink).

Parameters:
- DATA_WIDTH, 8, bits per signed activation element
- WEIGHT_WIDTH, 8, bits per signed weight
- OUTPUT_WIDTH, 32, accumulator and result width per lane
- MAC_NUM, 8, number of lanes
- K_WIDTH, 16, width of the job-length field
- SAT_EN, 1, 1 = saturate accumulation, 0 = two's-complement wrap
- WEIGHT_BCAST, 1, 1 = one weight shared by all lanes, 0 = one weight per lane
- WN = WEIGHT_BCAST ? WEIGHT_WIDTH : WEIGHT_WIDTH*MAC_NUM (derived, local)

Ports:
- clk_i, input, 1, clock; all state changes on rising edge
- rst_i, input, 1, asynchronous active-high reset
- start_i, input, 1, begin a job; sampled only in IDLE
- k_len_i, input, K_WIDTH, beats in the job; sampled with start_i
- clear_i, input, 1, synchronous abort
- in_valid_i, input, 1, input beat valid
- in_ready_o, output, 1, block accepts a beat
- din_i, input, DATA_WIDTH*MAC_NUM, signed activations; lane i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- win_i, input, WN, signed weight(s); per-lane slicing matches din_i
- out_valid_o, output, 1, result register holds an unconsumed result
- out_ready_i, input, 1, sink accepts the result
- matmul_o, output, OUTPUT_WIDTH*MAC_NUM, per-lane results; lane i at [i*OUTPUT_WIDTH +: OUTPUT_WIDTH]
- ovf_o, output, MAC_NUM, per-lane sticky overflow for the job in matmul_o
- busy_o, output, 1, state is not IDLE

Behaviour:
- Reset (rst_i = 1, any time, including mid-job):
  - FSM goes to IDLE.
  - Accumulators, product registers, beat counter, matmul_o, ovf_o, out_valid_o, in_ready_o and busy_o all go to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i = 1 and k_len_i != 0: latch k_len_i, zero the accumulators and per-lane overflow, go to RUN.
  - start_i with k_len_i == 0 is ignored; the FSM stays in IDLE.
- RUN:
  - in_ready_o = 1 only in RUN.
  - A beat is accepted when in_valid_i & in_ready_o.
  - On each accepted beat, every lane registers product p_i = din_i lane × weight (full DATA_WIDTH+WEIGHT_WIDTH signed) and the product-valid bit is set.
  - Each product is added to its accumulator on the following edge.
  - The beat counter increments on each accept. The edge that accepts beat k_len goes to DRAIN.
- DRAIN: one cycle. The last product accumulates, then the FSM goes to DONE.
- DONE:
  - If !out_valid_o | out_ready_i: copy the accumulators to matmul_o and the overflow flags to ovf_o, set out_valid_o, go to IDLE.
  - Otherwise stall in DONE; accumulators hold.
- Latency: out_valid_o rises 2 edges after the edge that accepted the last beat, when the output register is free.
- Output handshake:
  - out_valid_o clears on out_valid_o & out_ready_i unless the same edge reloads it from DONE, in which case it stays 1 with new data.
  - matmul_o is stable while out_valid_o & !out_ready_i.
- Accumulate arithmetic: the product is sign-extended to OUTPUT_WIDTH+1 and summed with the accumulator.
  - SAT_EN = 1: on overflow, clamp to 2^(OUTPUT_WIDTH-1)-1 or -2^(OUTPUT_WIDTH-1) and set the lane flag.
  - SAT_EN = 0: keep the low OUTPUT_WIDTH bits; the flag is still set on signed overflow.
- clear_i (priority below rst_i, above everything else):
  - Next edge forces IDLE and zeroes the accumulators, product-valid bit and counter.
  - The output register and out_valid_o are unaffected.
  - clear_i together with start_i: clear wins, the job does not start.
- start_i outside IDLE is ignored.
- in_valid_i outside RUN is not accepted.
- Counter wrap is impossible, since the counter width is K_WIDTH and it stops at k_len.

Decomposition:
- Package pu_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - saturating-add function, parametrised by width
  - lane slice-offset helpers
- Sub-module pu_lane: one lane containing the product register, accumulator, saturate/wrap logic and overflow flag.
  - Controls: acc_en, clr.
  - Instantiated MAC_NUM times by generate; the top holds the FSM, counter and output register.

Test Plan:
- Basic job: k_len=4, all lanes din=3, win=2, out_ready_i=1 → matmul_o every lane = 24, ovf_o=0, out_valid_o 2 edges after the 4th accept.
- Back-pressure on both sides:
  - Toggle in_valid_i randomly, hold out_ready_i=0; first job k_len=2 (din lane i = i, win=-5) gives lane i = -10i.
  - Second job completes while first is unconsumed → DONE stalls, first result stays stable.
  - Raise out_ready_i → second result loads with out_valid_o continuously 1.
- Saturation:
  - OUTPUT_WIDTH=16, SAT_EN=1, din=127, win=127, k_len=3 → 32767, ovf_o all 1.
  - SAT_EN=0 → 48387 mod 2^16 = -17149, ovf_o all 1.
- Per-lane weights: WEIGHT_BCAST=0, din=1, lane i weight = i-4, k_len=5 → lane i = 5(i-4).
- Abort, edges and reset:
  - clear_i after beat 2 of k_len=6 → IDLE, no out_valid_o.
  - Restarted k_len=1 gives the correct single product.
  - start_i with k_len=0 keeps busy_o=0.
  - rst_i mid-RUN clears all outputs asynchronously.
